// File: rtl/la_ioring_pkg.sv
`default_nettype none
// ============================================================================
// Module  : la_ioring_pkg
// Purpose : Shared definitions for the ioring sequencer: FSM state encodings
//           and the width helper for the "bits set" index.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package la_ioring_pkg;

  // Sequencer states (2-bit encoding kept stable for legacy consumers)
  localparam logic [1:0] ST_OFF       = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_ON        = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  // idx counts set bits in [0, RINGW], so it needs RINGW+1 distinct values
  function automatic int idx_width(input int ringw);
    return $clog2(ringw + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/la_dsync.sv
`default_nettype none
// ============================================================================
// Module  : la_dsync
// Purpose : Two-flop synchronizer bringing an asynchronous level into clk.
// Ports   : clk   in  clock
//           reset in  asynchronous active-high reset (clears both stages)
//           d     in  asynchronous input level
//           q     out synchronized level, two clk edges behind d
// Rev     : 1.0  initial release
// ============================================================================
module la_dsync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/la_ioring_seq.sv
`default_nettype none
// ============================================================================
// Module  : la_ioring_seq
// Purpose : Ramps the RINGW-bit ioring control bus one bit at a time (LSB
//           first on power-up, MSB first on power-down) with a programmable
//           gap between steps, so ring segments never switch simultaneously.
// Ports   : clk        in  clock
//           reset      in  asynchronous active-high reset
//           pwr_req    in  level request, 1 = ring on
//           step_delay in  idle cycles between bit steps (sampled at reload)
//           ioring     out thermometer-coded ring control bus
//           pwr_ack    out 1 while the whole ring is on (state ON)
//           busy       out 1 while ramping in either direction
// Rev     : 1.0  initial release
// ============================================================================
module la_ioring_seq
  import la_ioring_pkg::*;
#(
  parameter string PROP  = "DEFAULT",
  parameter int    RINGW = 8,
  parameter int    CNTW  = 8,
  parameter int    SYNC  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwr_req,
  input  logic [CNTW-1:0]  step_delay,
  output logic [RINGW-1:0] ioring,
  output logic             pwr_ack,
  output logic             busy
);

  localparam int              IDXW     = idx_width(RINGW);
  localparam logic [IDXW-1:0] IDX_FULL = IDXW'(RINGW);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(RINGW - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  logic req;

  generate
    if (SYNC != 0) begin : g_sync
      la_dsync u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pwr_req),
        .q     (req)
      );
    end else begin : g_nosync
      assign req = pwr_req;
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q,   idx_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;
  logic [RINGW-1:0] ioring_q, ioring_d;
  logic             pwr_ack_q, pwr_ack_d;
  logic             busy_q,    busy_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_OFF: begin
        if (req) begin
          state_d = ST_RAMP_UP;
          cnt_d   = step_delay;
        end
      end

      ST_RAMP_UP: begin
        // A reversal only reloads the gap; bits hold on this edge so no bit
        // is toggled twice.
        if (!req) begin
          state_d = ST_RAMP_DOWN;
          cnt_d   = step_delay;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          cnt_d = step_delay;
          // ">=" also covers a reversal that re-enters with the ring full
          if (idx_q >= IDX_LAST) begin
            idx_d   = IDX_FULL;
            state_d = ST_ON;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      ST_ON: begin
        if (!req) begin
          state_d = ST_RAMP_DOWN;
          cnt_d   = step_delay;
        end
      end

      ST_RAMP_DOWN: begin
        if (req) begin
          state_d = ST_RAMP_UP;
          cnt_d   = step_delay;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          cnt_d = step_delay;
          // "<=" also covers a reversal taken before the first bit rose
          if (idx_q <= IDX_ONE) begin
            idx_d   = '0;
            state_d = ST_OFF;
          end else begin
            idx_d = idx_q - IDX_ONE;
          end
        end
      end

      default: begin
        state_d = ST_OFF;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // The ring register is rebuilt from the next idx, which keeps it a
  // thermometer code by construction.
  always_comb begin
    ioring_d = '0;
    for (int i = 0; i < RINGW; i++) begin
      ioring_d[i] = (IDXW'(i) < idx_d);
    end
    pwr_ack_d = (state_d == ST_ON);
    busy_d    = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_OFF;
      idx_q     <= '0;
      cnt_q     <= '0;
      ioring_q  <= '0;
      pwr_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ioring_q  <= ioring_d;
      pwr_ack_q <= pwr_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign ioring  = ioring_q;
  assign pwr_ack = pwr_ack_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_la_ioring_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_la_ioring_seq
// Purpose : Self-checking bench for la_ioring_seq. Stimulus pushes expected
//           outputs tagged with the clock edge they belong to; a monitor pops
//           and compares them on the falling edge.
// Rev     : 1.0  initial release
// ============================================================================
module tb_la_ioring_seq;

  logic       clk;
  logic       clk_en;
  logic       reset, reset_s;
  logic       pwr_req, pwr_req_s;
  logic [7:0] step_delay, step_delay_s;
  logic [7:0] ioring, ioring_s;
  logic       pwr_ack, pwr_ack_s;
  logic       busy, busy_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    bit         sel;
    logic [7:0] ring;
    logic       ack;
    logic       busy;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  la_ioring_seq #(.RINGW(8), .CNTW(8), .SYNC(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .pwr_req    (pwr_req),
    .step_delay (step_delay),
    .ioring     (ioring),
    .pwr_ack    (pwr_ack),
    .busy       (busy)
  );

  la_ioring_seq #(.RINGW(8), .CNTW(8), .SYNC(1)) dut_s (
    .clk        (clk),
    .reset      (reset_s),
    .pwr_req    (pwr_req_s),
    .step_delay (step_delay_s),
    .ioring     (ioring_s),
    .pwr_ack    (pwr_ack_s),
    .busy       (busy_s)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [7:0] ar, input logic aa, input logic ab,
                     input logic [7:0] er, input logic ea, input logic eb);
    total++;
    if (ar !== er || aa !== ea || ab !== eb) begin
      bad++;
      $display("FAIL %s: got ring=%h ack=%b busy=%b, want ring=%h ack=%b busy=%b",
               nm, ar, aa, ab, er, ea, eb);
    end
  endtask

  function automatic void push(input int c, input bit s, input logic [7:0] r,
                               input logic a, input logic b, input string n);
    exp_t x;
    x.cyc  = c;
    x.sel  = s;
    x.ring = r;
    x.ack  = a;
    x.busy = b;
    x.nm   = n;
    sb.push_back(x);
  endfunction

  // Monitor: outputs only change on the rising edge, so sample on the falling one
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s@%0d: sample missed, now at edge %0d", e.nm, e.cyc, cyc);
      end else if (e.sel) begin
        chk($sformatf("%s@%0d", e.nm, e.cyc), ioring_s, pwr_ack_s, busy_s,
            e.ring, e.ack, e.busy);
      end else begin
        chk($sformatf("%s@%0d", e.nm, e.cyc), ioring, pwr_ack, busy,
            e.ring, e.ack, e.busy);
      end
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations still pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    clk_en       = 1'b0;
    reset        = 1'b0;
    reset_s      = 1'b0;
    pwr_req      = 1'b0;
    pwr_req_s    = 1'b0;
    step_delay   = 8'd2;
    step_delay_s = 8'd0;

    // 1. Asynchronous reset with the clock stopped
    #3 reset = 1'b1; reset_s = 1'b1;
    #1;
    chk("rst_async", ioring, pwr_ack, busy, 8'h00, 1'b0, 1'b0);
    chk("rst_async_s", ioring_s, pwr_ack_s, busy_s, 8'h00, 1'b0, 1'b0);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    reset_s = 1'b0;

    // 2. Ramp-up, D=2: bit k rises 3k edges after the sampling edge
    @(negedge clk);
    pwr_req = 1'b1;
    n = cyc + 1;
    push(n, 0, 8'h00, 1'b0, 1'b1, "up_start");
    for (int k = 1; k <= 8; k++) begin
      push(n + 3*k - 1, 0, 8'((1 << (k-1)) - 1), 1'b0, 1'b1, "up_pre");
      push(n + 3*k, 0, 8'((1 << k) - 1), 1'(k == 8), 1'(k != 8), "up_step");
    end
    drain(100);
    push(cyc + 2, 0, 8'hFF, 1'b1, 1'b0, "on_hold");
    drain(10);

    // 3. Ramp-down, D=2: ack drops at once, bits clear MSB first
    pwr_req = 1'b0;
    n = cyc + 1;
    push(n, 0, 8'hFF, 1'b0, 1'b1, "dn_ack");
    for (int k = 1; k <= 8; k++) begin
      push(n + 3*k - 1, 0, 8'(8'hFF >> (k-1)), 1'b0, 1'b1, "dn_pre");
      push(n + 3*k, 0, 8'(8'hFF >> k), 1'b0, 1'(k != 8), "dn_step");
    end
    drain(100);

    // 4. Reversals with D=0
    step_delay = 8'd0;
    pwr_req    = 1'b1;
    n = cyc;
    push(n + 1,  0, 8'h00, 1'b0, 1'b1, "rv_start");
    push(n + 2,  0, 8'h01, 1'b0, 1'b1, "rv_up1");
    push(n + 3,  0, 8'h03, 1'b0, 1'b1, "rv_up2");
    push(n + 4,  0, 8'h07, 1'b0, 1'b1, "rv_up3");
    push(n + 5,  0, 8'h07, 1'b0, 1'b1, "rv_hold");
    push(n + 6,  0, 8'h03, 1'b0, 1'b1, "rv_dn1");
    push(n + 7,  0, 8'h01, 1'b0, 1'b1, "rv_dn2");
    push(n + 8,  0, 8'h01, 1'b0, 1'b1, "rv_rehold");
    push(n + 9,  0, 8'h03, 1'b0, 1'b1, "rv_reup");
    push(n + 10, 0, 8'h03, 1'b0, 1'b1, "rv_hold2");
    push(n + 11, 0, 8'h01, 1'b0, 1'b1, "rv_dn3");
    push(n + 12, 0, 8'h00, 1'b0, 1'b0, "rv_off");
    at_cyc(n + 4); pwr_req = 1'b0;
    at_cyc(n + 7); pwr_req = 1'b1;
    at_cyc(n + 9); pwr_req = 1'b0;
    drain(50);

    // 5. Async reset in the middle of a ramp-up, then restart from bit 0
    @(negedge clk);
    pwr_req = 1'b1;
    n = cyc;
    push(n + 6, 0, 8'h1F, 1'b0, 1'b1, "pre_rst");
    at_cyc(n + 6);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid", ioring, pwr_ack, busy, 8'h00, 1'b0, 1'b0);
    drain(10);
    @(negedge clk);
    reset = 1'b0;
    n = cyc;
    push(n + 1, 0, 8'h00, 1'b0, 1'b1, "rs_edge");
    push(n + 2, 0, 8'h01, 1'b0, 1'b1, "rs_b0");
    push(n + 3, 0, 8'h03, 1'b0, 1'b1, "rs_b1");
    drain(20);

    // 6. Synchronized request, D=0 then 5 mid-ramp
    @(negedge clk);
    pwr_req_s = 1'b1;
    n = cyc;
    push(n + 2,  1, 8'h00, 1'b0, 1'b0, "sy_lat");
    push(n + 3,  1, 8'h00, 1'b0, 1'b1, "sy_busy");
    push(n + 4,  1, 8'h01, 1'b0, 1'b1, "sy_b0");
    push(n + 5,  1, 8'h03, 1'b0, 1'b1, "sy_b1");
    push(n + 6,  1, 8'h07, 1'b0, 1'b1, "sy_b2");
    push(n + 11, 1, 8'h07, 1'b0, 1'b1, "sy_gap");
    push(n + 12, 1, 8'h0F, 1'b0, 1'b1, "sy_b3");
    push(n + 17, 1, 8'h0F, 1'b0, 1'b1, "sy_gap2");
    push(n + 18, 1, 8'h1F, 1'b0, 1'b1, "sy_b4");
    at_cyc(n + 5);
    step_delay_s = 8'd5;
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
